// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_fifo_if
// Brief   : Write-side and serial-side signal bundle of the buffered UART TX.
// Revision: 1.0 - initial release
// ============================================================================
interface uart_tx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic                 rw;
    logic [DATA_BITS-1:0] din;
    logic                 full;
    logic [LW-1:0]        level;
    logic                 busy;
    logic                 done;
    logic                 tx;

    modport master (output rw, din, input full, level, busy, done, tx);
    modport slave  (input rw, din, output full, level, busy, done, tx);
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_fifo
// Brief   : Byte FIFO feeding a configurable start/data/parity/stop serialiser.
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic      clk_in,
    input  wire logic      reset,
    uart_tx_fifo_if.slave  bus
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] c_BAUD_LAST = CW'(DIV - 1);
    localparam logic [3:0]    c_DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    c_STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic          c_ODD       = (PARITY == 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;

    // ---------------- FIFO ----------------
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]          wr_ptr_q, rd_ptr_q;
    logic                 rw_q;
    logic                 empty, full, push, pop;
    logic [DATA_BITS-1:0] head;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];
    // A simultaneous pop frees the slot, so a push while full still lands.
    assign push  = bus.rw & ~rw_q & (~full | pop);

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            rw_q     <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            rw_q <= bus.rw;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= bus.din;
    end

    assign bus.full  = full;
    assign bus.level = wr_ptr_q - rd_ptr_q;

    // ---------------- Serialiser ----------------
    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        baud_q, baud_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 baud_end;

    assign baud_end = (baud_q == c_BAUD_LAST);

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q <= c_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        pop     = 1'b0;
        case (state_q)
            c_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = c_START;
                    baud_d  = '0;
                    shift_d = head;
                    par_d   = (^head) ^ c_ODD;
                end
            end
            c_START: begin
                if (baud_end) begin
                    state_d = c_DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            c_DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == c_DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? c_PARITY : c_STOP;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            c_PARITY: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = c_STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            c_STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == c_STOP_LAST) begin
                        bit_d = '0;
                        // Chain straight into the next frame without an idle bit.
                        if (!empty) begin
                            pop     = 1'b1;
                            state_d = c_START;
                            shift_d = head;
                            par_d   = (^head) ^ c_ODD;
                        end else begin
                            state_d = c_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    // Line level follows the next state so tx changes on the same edge as the state.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            c_START:  tx_d = 1'b0;
            c_DATA:   tx_d = shift_d[0];
            c_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
    end

    assign bus.tx   = tx_q;
    assign bus.busy = (state_q != c_IDLE);
    assign bus.done = (state_q == c_STOP) && baud_end && (bit_q == c_STOP_LAST);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_fifo
// Brief   : Three configurations of uart_tx_fifo against a frame-timeline model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;
    logic clk_in = 1'b0;
    logic reset  = 1'b1;
    always #5 clk_in = ~clk_in;

    logic [2:0]      rw_v;
    logic [2:0][8:0] din_v;

    uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if0 ();
    uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) if1 ();
    uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if2 ();

    assign if0.rw = rw_v[0];  assign if0.din = din_v[0][7:0];
    assign if1.rw = rw_v[1];  assign if1.din = din_v[1][6:0];
    assign if2.rw = rw_v[2];  assign if2.din = din_v[2][7:0];

    uart_tx_fifo #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
        dut0 (.clk_in(clk_in), .reset(reset), .bus(if0));
    uart_tx_fifo #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4))
        dut1 (.clk_in(clk_in), .reset(reset), .bus(if1));
    uart_tx_fifo #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4))
        dut2 (.clk_in(clk_in), .reset(reset), .bus(if2));

    wire [6:0] obs0 = {if0.tx, if0.busy, if0.done, if0.full, if0.level};
    wire [6:0] obs1 = {if1.tx, if1.busy, if1.done, if1.full, if1.level};
    wire [6:0] obs2 = {if2.tx, if2.busy, if2.done, if2.full, if2.level};

    int n_checks = 0;
    int n_err    = 0;
    int busy_cnt [3];
    int done_cnt [3];

    // Model: a frame is a list of line bits, each held 16 clocks; pending bytes wait in mq.
    int mpos [3];
    int mcur [3];
    int mcnt [3];
    int mq   [3][4];
    bit mprev[3];

    function automatic int db_of(int d);   return (d == 1) ? 7 : 8;                     endfunction
    function automatic int par_of(int d);  return (d == 1) ? 2 : ((d == 2) ? 1 : 0);    endfunction
    function automatic int stop_of(int d); return (d == 1) ? 2 : 1;                     endfunction
    function automatic int flen(int d);
        return (1 + db_of(d) + ((par_of(d) != 0) ? 1 : 0) + stop_of(d)) * 16;
    endfunction

    function automatic logic fbit(int d, int b, int pos);
        int idx = pos / 16;
        int n   = db_of(d);
        int x   = 0;
        if (idx == 0) return 1'b0;
        if (idx <= n) return b[idx-1];
        if (par_of(d) != 0 && idx == n + 1) begin
            for (int i = 0; i < n; i++) x = x ^ ((b >> i) & 1);
            return (par_of(d) == 1) ? (x == 0) : (x != 0);
        end
        return 1'b1;
    endfunction

    function automatic logic [6:0] expected(int d);
        logic t = (mpos[d] < 0) ? 1'b1 : fbit(d, mcur[d], mpos[d]);
        return {t, mpos[d] >= 0, mpos[d] == flen(d) - 1, mcnt[d] == 4, 3'(mcnt[d])};
    endfunction

    function automatic logic [6:0] obs_of(int d);
        return (d == 0) ? obs0 : ((d == 1) ? obs1 : obs2);
    endfunction

    task automatic model_step(int d);
        bit rise;
        if (!reset) begin
            mpos[d] = -1; mcnt[d] = 0; mprev[d] = 1'b0;
            return;
        end
        rise     = rw_v[d] && !mprev[d];
        mprev[d] = rw_v[d];
        if (mpos[d] >= 0 && mpos[d] < flen(d) - 1) mpos[d]++;
        else if (mcnt[d] > 0) begin
            mcur[d] = mq[d][0];
            for (int i = 0; i < 3; i++) mq[d][i] = mq[d][i+1];
            mcnt[d]--;
            mpos[d] = 0;
        end else mpos[d] = -1;
        if (rise && mcnt[d] < 4) begin
            mq[d][mcnt[d]] = int'(din_v[d]) & ((1 << db_of(d)) - 1);
            mcnt[d]++;
        end
    endtask

    task automatic check_vec(input string tag, input logic [6:0] got, input logic [6:0] want);
        n_checks++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed {tx,busy,done,full,level}=%b expected %b", tag, got, want);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int want);
        n_checks++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic tick();
        logic [6:0] o;
        @(posedge clk_in);
        for (int d = 0; d < 3; d++) model_step(d);
        @(negedge clk_in);
        for (int d = 0; d < 3; d++) begin
            o = obs_of(d);
            check_vec((d == 0) ? "line0" : ((d == 1) ? "line1" : "line2"), o, expected(d));
            if (o[5]) busy_cnt[d]++;
            if (o[4]) done_cnt[d]++;
        end
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_counts();
        for (int d = 0; d < 3; d++) begin busy_cnt[d] = 0; done_cnt[d] = 0; end
    endtask

    task automatic pulse(int d, logic [8:0] val);
        rw_v[d] = 1'b1; din_v[d] = val;
        tick();
        rw_v[d] = 1'b0; din_v[d] = 9'($urandom_range(0, 511));
    endtask

    initial begin
        bit found;
        rw_v = '0; din_v = '0;
        for (int d = 0; d < 3; d++) begin mpos[d] = -1; mcnt[d] = 0; mprev[d] = 1'b0; mcur[d] = 0; end
        clear_counts();
        #1 reset = 1'b0;
        ticks(5);
        reset = 1'b1;

        // Single 0x33 frame: 160 busy clocks and one done pulse
        clear_counts();
        pulse(0, 9'h033);
        ticks(200);
        check_int("t1_busy_clocks", busy_cnt[0], 160);
        check_int("t1_done_pulses", done_cnt[0], 1);

        // Held write request produces exactly one frame
        clear_counts();
        rw_v[0] = 1'b1; din_v[0] = 9'h033;
        ticks(4000);
        rw_v[0] = 1'b0;
        tick();
        check_int("t2_done_pulses", done_cnt[0], 1);

        // Six pulses: shifter + four FIFO entries, sixth dropped
        clear_counts();
        for (int i = 0; i < 6; i++) begin
            pulse(0, 9'($urandom_range(0, 255)));
            ticks(3);
        end
        check_int("t3_fill_level", int'(if0.level), 4);
        check_int("t3_fill_full", int'(if0.full), 1);
        ticks(850);
        check_int("t3_done_pulses", done_cnt[0], 5);

        // Push arriving on the pop edge while full is accepted
        clear_counts();
        for (int i = 0; i < 5; i++) begin
            pulse(0, 9'($urandom_range(0, 255)));
            ticks(3);
        end
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (mpos[0] == flen(0) - 1) found = 1'b1;
            else tick();
        end
        check_int("t3b_align", int'(found), 1);
        pulse(0, 9'h0C3);
        check_int("t3b_level_kept", int'(if0.level), 4);
        check_int("t3b_full_kept", int'(if0.full), 1);
        ticks(1000);
        check_int("t3b_done_pulses", done_cnt[0], 6);

        // 7 data bits, even parity, two stop bits
        clear_counts();
        pulse(1, 9'h055);
        ticks(200);
        check_int("t4_busy_clocks", busy_cnt[1], 176);
        check_int("t4_done_pulses", done_cnt[1], 1);

        // Odd parity on 0x00 and 0x01
        clear_counts();
        pulse(2, 9'h000);
        ticks(200);
        pulse(2, 9'h001);
        ticks(200);
        check_int("t5_done_pulses", done_cnt[2], 2);

        // Randomised writes on all three configurations
        for (int i = 0; i < 3000; i++) begin
            for (int d = 0; d < 3; d++) begin
                rw_v[d]  = ($urandom_range(0, 7) == 0);
                din_v[d] = 9'($urandom_range(0, 511));
            end
            tick();
        end
        rw_v = '0;
        ticks(1200);

        // Reset during data bit 3 with one byte still queued
        pulse(0, 9'h0A5);
        ticks(10);
        pulse(0, 9'h05A);
        ticks(58);
        check_int("t6_busy_before", int'(if0.busy), 1);
        clear_counts();
        reset = 1'b0;
        #1;
        check_vec("t6_async_abort", obs0, 7'b1000000);
        ticks(3);
        reset = 1'b1;
        ticks(200);
        check_int("t6_no_done", done_cnt[0], 0);
        pulse(0, 9'h03C);
        ticks(200);
        check_int("t6_resume_done", done_cnt[0], 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
